// File: rtl/bits_to_bytes_stream_if.sv
// bits_to_bytes_stream_if: bit-in / byte-out stream bundle; master = producer+consumer side, slave = packer
interface bits_to_bytes_stream_if #(
  parameter int IN_W = 8,
  parameter int OUT_B = 1
) ();
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_bits;
  logic out_valid;
  logic out_ready;
  logic [8*OUT_B-1:0] out_bytes;
  logic out_last;
  modport master (
    output in_valid, in_bits, out_ready,
    input in_ready, out_valid, out_bytes, out_last
  );
  modport slave (
    input in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bytes, out_last
  );
endinterface

// File: rtl/bits_to_bytes_stream.sv
// bits_to_bytes_stream: packs IN_W-bit beats LSB-first into OUT_B-byte beats, out_last per BYTE_LEN-byte message; ports clk, rst, s (stream bundle), busy
module bits_to_bytes_stream #(
  parameter int BYTE_LEN = 32,
  parameter int IN_W = 8,
  parameter int OUT_B = 1
) (
  input logic clk,
  input logic rst,
  bits_to_bytes_stream_if.slave s,
  output logic busy
);
  localparam int OW = 8 * OUT_B;
  localparam int ACC_W = OW + IN_W;
  localparam int CW = $clog2(ACC_W + 1);
  localparam int BITS = BYTE_LEN * 8;
  localparam int IW = $clog2(BITS + 1);
  localparam int OCW = $clog2(BYTE_LEN + 1);
  localparam logic [CW-1:0] OW_C = CW'(OW);
  localparam logic [CW-1:0] IN_C = CW'(IN_W);
  localparam logic [IW-1:0] ILAST = IW'(BITS - IN_W);
  localparam logic [IW-1:0] ISTEP = IW'(IN_W);
  localparam logic [OCW-1:0] OLAST = OCW'(BYTE_LEN - OUT_B);
  localparam logic [OCW-1:0] OSTEP = OCW'(OUT_B);
  generate
    if (BYTE_LEN % OUT_B != 0 || BITS % IN_W != 0 || IN_W < 1 || IN_W > 64 || OUT_B < 1 || OUT_B > 8) begin : g_bad
      $error("bits_to_bytes_stream: illegal BYTE_LEN/IN_W/OUT_B combination");
    end
  endgenerate
  logic [ACC_W-1:0] acc, acc_next;
  logic [CW-1:0] cnt, pos, cnt_next;
  logic [IW-1:0] icnt;
  logic [OCW-1:0] ocnt;
  logic in_fire, out_fire;
  assign s.in_ready = cnt <= OW_C;
  assign s.out_valid = cnt >= OW_C;
  assign s.out_bytes = acc[OW-1:0];
  assign s.out_last = s.out_valid && ocnt == OLAST;
  assign busy = cnt != '0 || icnt != '0 || ocnt != '0;
  always_comb begin
    in_fire = s.in_valid && s.in_ready;
    out_fire = s.out_valid && s.out_ready;
    pos = out_fire ? cnt - OW_C : cnt;
    cnt_next = pos + (in_fire ? IN_C : '0);
    acc_next = (out_fire ? acc >> OW : acc) | (in_fire ? {{OW{1'b0}}, s.in_bits} << pos : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      icnt <= '0;
      ocnt <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (in_fire) icnt <= icnt == ILAST ? '0 : icnt + ISTEP;
      if (out_fire) ocnt <= s.out_last ? '0 : ocnt + OSTEP;
    end
  end
endmodule

// File: tb/tb_bits_to_bytes_stream.sv
// tb_bits_to_bytes_stream: directed tables plus a randomized bit-queue scoreboard over four parameterizations
module tb_bits_to_bytes_stream;
  logic clk, rst;
  logic busy0, busy1, busy2, busy3;
  int n_cmp, n_bad;
  bits_to_bytes_stream_if #(.IN_W(8), .OUT_B(1)) i0 ();
  bits_to_bytes_stream_if #(.IN_W(1), .OUT_B(1)) i1 ();
  bits_to_bytes_stream_if #(.IN_W(12), .OUT_B(2)) i2 ();
  bits_to_bytes_stream_if #(.IN_W(5), .OUT_B(1)) i3 ();
  bits_to_bytes_stream #(.BYTE_LEN(32), .IN_W(8), .OUT_B(1)) u0 (.clk(clk), .rst(rst), .s(i0), .busy(busy0));
  bits_to_bytes_stream #(.BYTE_LEN(1), .IN_W(1), .OUT_B(1)) u1 (.clk(clk), .rst(rst), .s(i1), .busy(busy1));
  bits_to_bytes_stream #(.BYTE_LEN(6), .IN_W(12), .OUT_B(2)) u2 (.clk(clk), .rst(rst), .s(i2), .busy(busy2));
  bits_to_bytes_stream #(.BYTE_LEN(5), .IN_W(5), .OUT_B(1)) u3 (.clk(clk), .rst(rst), .s(i3), .busy(busy3));
  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_b;
    logic exp_l;
  } vec_t;
  vec_t tab[32];
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset;
    i0.in_valid = 0; i1.in_valid = 0; i2.in_valid = 0; i3.in_valid = 0;
    i0.out_ready = 0; i1.out_ready = 0; i2.out_ready = 0; i3.out_ready = 0;
    i0.in_bits = 0; i1.in_bits = 0; i2.in_bits = 0; i3.in_bits = 0;
    rst = 1;
    step;
    step;
    rst = 0;
  endtask
  initial begin
    logic [7:0] bits1;
    logic [11:0] w2[4];
    logic [15:0] b2[3];
    logic [2:0] l2;
    logic bq[$];
    logic [7:0] got;
    int k, nb, beats, nbytes;
    logic fi, fo;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) tab[i] = '{din: 8'(i), exp_b: 8'(i), exp_l: i == 31};
    bits1 = 8'b0000_1101;
    w2 = '{12'hABC, 12'h123, 12'h456, 12'h789};
    b2 = '{16'h3ABC, 16'h5612, 16'h7894};
    l2 = 3'b100;
    do_reset;
    check("rst in_ready", i0.in_ready, 1);
    check("rst out_valid", i0.out_valid, 0);
    check("rst out_last", i0.out_last, 0);
    check("rst out_bytes", i0.out_bytes, 0);
    check("rst busy", busy0, 0);
    i0.out_ready = 1;
    for (int i = 0; i < 32; i++) begin
      i0.in_valid = 1;
      i0.in_bits = tab[i].din;
      step;
      check("t1 out_valid", i0.out_valid, 1);
      check("t1 out_bytes", i0.out_bytes, tab[i].exp_b);
      check("t1 out_last", i0.out_last, tab[i].exp_l);
    end
    i0.in_valid = 0;
    step;
    check("t1 drained valid", i0.out_valid, 0);
    check("t1 idle busy", busy0, 0);
    i1.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("t2 in_ready", i1.in_ready, 1);
      check("t2 early valid", i1.out_valid, 0);
      i1.in_valid = 1;
      i1.in_bits = bits1[i];
      step;
    end
    i1.in_valid = 0;
    check("t2 out_valid", i1.out_valid, 1);
    check("t2 out_bytes", i1.out_bytes, 8'h0D);
    check("t2 out_last", i1.out_last, 1);
    check("t2 in_ready full", i1.in_ready, 1);
    step;
    check("t2 drained valid", i1.out_valid, 0);
    check("t2 idle busy", busy1, 0);
    i2.out_ready = 1;
    k = 0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 3; c++) begin
      i2.in_valid = k < 4;
      i2.in_bits = k < 4 ? w2[k] : 12'h0;
      fi = i2.in_valid && i2.in_ready;
      fo = i2.out_valid && i2.out_ready;
      if (fo) begin
        check("t3 beat", i2.out_bytes, b2[nb]);
        check("t3 last", i2.out_last, l2[nb]);
        nb++;
      end
      step;
      if (fi) k++;
    end
    i2.in_valid = 0;
    check("t3 beat count", nb, 3);
    check("t3 idle busy", busy2, 0);
    do_reset;
    i0.in_valid = 1;
    i0.in_bits = 8'hA5;
    step;
    i0.in_bits = 8'h3C;
    check("t4 first valid", i0.out_valid, 1);
    check("t4 first byte", i0.out_bytes, 8'hA5);
    check("t4 ready one more", i0.in_ready, 1);
    step;
    i0.in_bits = 8'h77;
    for (int i = 0; i < 4; i++) begin
      check("t4 stall valid", i0.out_valid, 1);
      check("t4 stall byte", i0.out_bytes, 8'hA5);
      check("t4 stall in_ready", i0.in_ready, 0);
      check("t4 stall last", i0.out_last, 0);
      if (i < 3) step;
    end
    i0.out_ready = 1;
    step;
    check("t4 second byte", i0.out_bytes, 8'h3C);
    check("t4 ready again", i0.in_ready, 1);
    step;
    i0.in_valid = 0;
    check("t4 third byte", i0.out_bytes, 8'h77);
    step;
    check("t4 drained valid", i0.out_valid, 0);
    check("t4 busy mid msg", busy0, 1);
    do_reset;
    i0.out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      i0.in_valid = 1;
      i0.in_bits = 8'(8'h80 + i);
      step;
    end
    i0.in_valid = 0;
    rst = 1;
    step;
    rst = 0;
    check("t5 rst out_valid", i0.out_valid, 0);
    check("t5 rst busy", busy0, 0);
    check("t5 rst in_ready", i0.in_ready, 1);
    for (int i = 0; i < 32; i++) begin
      i0.in_valid = 1;
      i0.in_bits = 8'(8'h40 + i);
      step;
      check("t5 byte", i0.out_bytes, 8'(8'h40 + i));
      check("t5 last", i0.out_last, i == 31);
    end
    i0.in_valid = 0;
    step;
    check("t5 idle busy", busy0, 0);
    beats = 0;
    nbytes = 0;
    for (int c = 0; c < 1400; c++) begin
      if (c < 1200) begin
        i3.in_valid = $urandom_range(0, 3) != 0;
        i3.out_ready = $urandom_range(0, 3) != 0;
      end else begin
        i3.in_valid = beats % 8 != 0;
        i3.out_ready = 1;
      end
      i3.in_bits = 5'($urandom);
      fi = i3.in_valid && i3.in_ready;
      fo = i3.out_valid && i3.out_ready;
      if (fo) begin
        if (bq.size() < 8) begin
          check("t6 spurious byte", bq.size(), 8);
        end else begin
          for (int b = 0; b < 8; b++) got[b] = bq.pop_front();
          check("t6 byte", i3.out_bytes, got);
          check("t6 last", i3.out_last, nbytes % 5 == 4);
          nbytes++;
        end
      end
      if (fi) begin
        for (int b = 0; b < 5; b++) bq.push_back(i3.in_bits[b]);
        beats++;
      end
      step;
    end
    i3.in_valid = 0;
    check("t6 leftover bits", bq.size(), 0);
    check("t6 byte total", nbytes, beats * 5 / 8);
    check("t6 idle busy", busy3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
